// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / decoded-immediate-out handshake bundle
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ir;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [XLEN-1:0] out_target;
  modport master (
    output in_valid, in_ir, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_target
  );
  modport slave (
    input  in_valid, in_ir, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_target
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I immediate, format and PC-target decoder with 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter int BR_SHIFT = 1
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  imm_gen_pipe_if.slave bus
);
  localparam int BW = 2 * XLEN + 4;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t          state, state_nx;
  logic [31:0]     ir;
  logic [6:0]      op;
  logic            is_auipc;
  logic [2:0]      fmt;
  logic [XLEN-1:0] imm, tgt;
  logic [BW-1:0]   dec, main_q, skid_q;
  logic            in_fire, out_fire;
  assign ir       = bus.in_ir;
  assign op       = ir[6:0];
  assign is_auipc = op == 7'b0010111;
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  always_comb begin
    fmt = op == 7'b0110011 ? 3'd0 :
          (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111) ? 3'd1 :
          op == 7'b0100011 ? 3'd2 :
          op == 7'b1100011 ? 3'd3 :
          (op == 7'b0110111 || is_auipc) ? 3'd4 :
          op == 7'b1101111 ? 3'd5 : 3'd7;
    imm = fmt == 3'd1 ? XLEN'($signed(ir[31:20])) :
          fmt == 3'd2 ? XLEN'($signed({ir[31:25], ir[11:7]})) :
          fmt == 3'd3 ? XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8]})) << BR_SHIFT :
          fmt == 3'd4 ? XLEN'($signed({ir[31:12], 12'h000})) :
          fmt == 3'd5 ? XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21]})) << BR_SHIFT : '0;
    tgt = (fmt == 3'd3 || fmt == 3'd5 || is_auipc) ? bus.in_pc + imm : '0;
    dec = {fmt == 3'd7, fmt, imm, tgt};
  end
  always_ff @(posedge clk)
    state <= (rst || flush) ? EMPTY : state_nx;
  always_comb
    state_nx = state == EMPTY ? (in_fire ? ONE : EMPTY) :
               state == ONE   ? ((in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE) :
               (out_fire ? ONE : FULL);
  always_ff @(posedge clk)
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if ((state == FULL && out_fire) || (in_fire && (state == EMPTY || out_fire)))
        main_q <= state == FULL ? skid_q : dec;
      if (in_fire && state == ONE && !out_fire)
        skid_q <= dec;
    end
  always_comb begin
    bus.in_ready  = state != FULL;
    bus.out_valid = state != EMPTY;
    {bus.out_illegal, bus.out_fmt, bus.out_imm, bus.out_target} = main_q;
  end
endmodule
